// File: rtl/pinball_pkg.sv
//------------------------------------------------------------------------------
// pinball_pkg : border indices and per-object hit record shared by collision logic
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pinball_pkg;

  localparam int NUM_BORDERS   = 4;
  localparam int BORDER_TOP    = 0;
  localparam int BORDER_BOTTOM = 1;
  localparam int BORDER_LEFT   = 2;
  localparam int BORDER_RIGHT  = 3;

  // One object's hits: object-overlap flag in the MSB, border sides below.
  typedef struct packed {
    logic                   obj;
    logic [NUM_BORDERS-1:0] side;
  } hit_t;

endpackage

`default_nettype wire

// File: rtl/collision_accumulator.sv
//------------------------------------------------------------------------------
// collision_accumulator : ORs one object's pixel hits over a frame and
//                         publishes the completed frame at startOfFrame
// Revision              : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module collision_accumulator
  import pinball_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  hit_t hit_i,
  output hit_t result_o
);

  hit_t acc_q, acc_d;
  hit_t res_q, res_d;

  always_comb begin
    acc_d = acc_q | hit_i;
    res_d = res_q;
    if (startOfFrame) begin
      // The start-of-frame pixel belongs to the new frame, not the published one.
      res_d = acc_q;
      acc_d = hit_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

`default_nettype wire

// File: rtl/collision_controller.sv
//------------------------------------------------------------------------------
// collision_controller : per-frame border/object collision detection with
//                        publish pulse and saturating collision-frame counter
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module collision_controller
  import pinball_pkg::*;
#(
  parameter int NUM_OBJECTS    = 4,
  parameter int OBJ_COLLIDE_EN = 1,
  parameter int COUNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame,
  input  logic [NUM_OBJECTS-1:0]     draw_objects,
  input  logic [NUM_BORDERS-1:0]     draw_borders,
  output logic [NUM_OBJECTS*4-1:0]   border_hit,
  output logic [NUM_OBJECTS-1:0]     object_hit,
  output logic [NUM_OBJECTS-1:0]     collision,
  output logic                       collision_pulse,
  output logic [COUNT_W-1:0]         collision_count
);

  logic [NUM_OBJECTS-1:0] obj_px;
  logic [NUM_OBJECTS-1:0] others;
  logic                   sof_q;
  logic [COUNT_W-1:0]     count_q, count_d;

  always_comb begin
    obj_px = '0;
    others = '0;
    for (int i = 0; i < NUM_OBJECTS; i++) begin
      others    = draw_objects & ~({{(NUM_OBJECTS-1){1'b0}}, 1'b1} << i);
      obj_px[i] = draw_objects[i] & (|others);
    end
    if (OBJ_COLLIDE_EN == 0) obj_px = '0;
  end

  for (genvar g = 0; g < NUM_OBJECTS; g++) begin : g_obj
    hit_t hit;
    hit_t res;

    assign hit.obj  = obj_px[g];
    assign hit.side = draw_borders & {NUM_BORDERS{draw_objects[g]}};

    collision_accumulator u_acc (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .hit_i        (hit),
      .result_o     (res)
    );

    assign border_hit[4*g +: 4] = res.side;
    assign object_hit[g]        = res.obj;
    assign collision[g]         = |res;
  end

  // sof_q marks the cycle in which freshly published results are visible.
  always_ff @(posedge clk) begin
    if (reset) sof_q <= 1'b0;
    else       sof_q <= startOfFrame;
  end

  assign collision_pulse = sof_q & (|collision);

  always_comb begin
    count_d = count_q;
    if (collision_pulse && (count_q != {COUNT_W{1'b1}}))
      count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign collision_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_collision_controller.sv
//------------------------------------------------------------------------------
// tb_collision_controller : directed vector table plus corner-case sequences
// Revision                : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_collision_controller;

  localparam int N  = 4;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset, sof;
  logic [N-1:0] objs;
  logic [3:0]   bord;

  logic [N*4-1:0] bh_a, bh_b;
  logic [N-1:0]   oh_a, oh_b, col_a, col_b;
  logic           p_a, p_b;
  logic [CW-1:0]  cnt_a, cnt_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  collision_controller #(.NUM_OBJECTS(N), .OBJ_COLLIDE_EN(1), .COUNT_W(CW)) dut_a (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (sof),
    .draw_objects    (objs),
    .draw_borders    (bord),
    .border_hit      (bh_a),
    .object_hit      (oh_a),
    .collision       (col_a),
    .collision_pulse (p_a),
    .collision_count (cnt_a)
  );

  collision_controller #(.NUM_OBJECTS(N), .OBJ_COLLIDE_EN(0), .COUNT_W(CW)) dut_b (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (sof),
    .draw_objects    (objs),
    .draw_borders    (bord),
    .border_hit      (bh_b),
    .object_hit      (oh_b),
    .collision       (col_b),
    .collision_pulse (p_b),
    .collision_count (cnt_b)
  );

  typedef struct packed {
    logic        sof;
    logic [3:0]  objs;
    logic [3:0]  bord;
    logic [15:0] bh;
    logic [3:0]  oh;
    logic [3:0]  col;
    logic        p;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic step(input logic r, input logic s, input logic [N-1:0] o, input logic [3:0] b);
    reset = r; sof = s; objs = o; bord = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    reset = 1'b1; sof = 1'b0; objs = '0; bord = '0;

    //            sof  objs     bord     bh        oh       col      p     cnt
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 4'b0010, 4'b0001, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 16'h0010, 4'b0000, 4'b0010, 1'b1, 4'd0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 16'h0010, 4'b0000, 4'b0010, 1'b0, 4'd1};
    tbl[4]  = '{1'b0, 4'b1001, 4'b0000, 16'h0010, 4'b0000, 4'b0010, 1'b0, 4'd1};
    tbl[5]  = '{1'b1, 4'b0100, 4'b0101, 16'h0000, 4'b1001, 4'b1001, 1'b1, 4'd1};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 16'h0000, 4'b1001, 4'b1001, 1'b0, 4'd2};
    tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 16'h0500, 4'b0000, 4'b0100, 1'b1, 4'd2};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd3};
    tbl[9]  = '{1'b0, 4'b0011, 4'b1010, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd3};
    tbl[10] = '{1'b1, 4'b0000, 4'b0000, 16'h00AA, 4'b0011, 4'b0011, 1'b1, 4'd3};
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 16'h00AA, 4'b0011, 4'b0011, 1'b0, 4'd4};

    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    chk("rst_bh",  32'(bh_a),  32'h0);
    chk("rst_oh",  32'(oh_a),  32'h0);
    chk("rst_col", 32'(col_a), 32'h0);
    chk("rst_p",   32'(p_a),   32'h0);
    chk("rst_cnt", 32'(cnt_a), 32'h0);

    for (int i = 0; i < 12; i++) begin
      step(1'b0, tbl[i].sof, tbl[i].objs, tbl[i].bord);
      chk($sformatf("t%0d_bh", i),  32'(bh_a),  32'(tbl[i].bh));
      chk($sformatf("t%0d_oh", i),  32'(oh_a),  32'(tbl[i].oh));
      chk($sformatf("t%0d_col", i), 32'(col_a), 32'(tbl[i].col));
      chk($sformatf("t%0d_p", i),   32'(p_a),   32'(tbl[i].p));
      chk($sformatf("t%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].cnt));
    end

    // Ten overlapping pixels of objects 0 and 3, with and without object detection.
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, '0, '0);
    repeat (10) step(1'b0, 1'b0, 4'b1001, 4'b0000);
    step(1'b0, 1'b1, '0, '0);
    chk("ov_a_oh",  32'(oh_a),  32'h9);
    chk("ov_a_p",   32'(p_a),   32'h1);
    chk("ov_b_oh",  32'(oh_b),  32'h0);
    chk("ov_b_col", 32'(col_b), 32'h0);
    chk("ov_b_p",   32'(p_b),   32'h0);
    step(1'b0, 1'b0, '0, '0);
    chk("ov_b_cnt", 32'(cnt_b), 32'h0);
    chk("ov_a_cnt", 32'(cnt_a), 32'h1);

    // Mid-frame hit discarded by a reset that coincides with startOfFrame.
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, 4'b0010, 4'b0001);
    step(1'b1, 1'b1, '0, '0);
    chk("rs_bh",  32'(bh_a),  32'h0);
    chk("rs_p",   32'(p_a),   32'h0);
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, '0, '0);
    chk("rs_pub_bh",  32'(bh_a),  32'h0);
    chk("rs_pub_col", 32'(col_a), 32'h0);
    chk("rs_pub_p",   32'(p_a),   32'h0);
    chk("rs_pub_cnt", 32'(cnt_a), 32'h0);
    step(1'b0, 1'b0, 4'b1000, 4'b1000);
    step(1'b0, 1'b1, '0, '0);
    chk("rs_post_bh",  32'(bh_a),  32'h8000);
    chk("rs_post_col", 32'(col_a), 32'h8);
    chk("rs_post_p",   32'(p_a),   32'h1);

    // Counter saturation over 20 colliding frames.
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, '0, '0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 4'b0010, 4'b0001);
      step(1'b0, 1'b1, '0, '0);
      chk($sformatf("sat%0d_p", k), 32'(p_a), 32'h1);
      step(1'b0, 1'b0, '0, '0);
      chk($sformatf("sat%0d_cnt", k), 32'(cnt_a), (k > 15) ? 32'd15 : 32'(k));
    end
    repeat (3) step(1'b0, 1'b0, '0, '0);
    chk("sat_hold", 32'(cnt_a), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/collision_controller.md
COLLISION_CONTROLLER -- requirements
Module: collision_controller

Interface
REQ-001 Parameter NUM_OBJECTS, default 4, is the number of drawable objects; legal range 2..8.
REQ-002 Parameter OBJ_COLLIDE_EN, default 1; 1 enables object-to-object detection, 0 forces all object-to-object results to 0.
REQ-003 Parameter COUNT_W, default 16, is the width of the collision frame counter.
REQ-004 clk  input  1  pixel clock, the only clock; all state is updated on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 startOfFrame  input  1  one-cycle pulse marking the first pixel of a frame.
REQ-007 draw_objects  input  NUM_OBJECTS  bit i is high when object i covers the current pixel.
REQ-008 draw_borders  input  4  bit 0 top, bit 1 bottom, bit 2 left, bit 3 right border covers the current pixel.
REQ-009 border_hit  output  NUM_OBJECTS*4  bits [4i+3:4i] are the border sides object i touched during the previous frame.
REQ-010 object_hit  output  NUM_OBJECTS  bit i is high when object i overlapped any other object during the previous frame.
REQ-011 collision  output  NUM_OBJECTS  bit i is the OR of object i's border_hit and object_hit bits.
REQ-012 collision_pulse  output  1  one-cycle pulse, high when any collision bit becomes valid for a new frame.
REQ-013 collision_count  output  COUNT_W  saturating count of frames in which any collision occurred.

Function
REQ-014 A pixel hit for object i and side s SHALL be draw_objects[i] AND draw_borders[s], evaluated every cycle.
REQ-015 An object pixel hit for object i SHALL be draw_objects[i] AND (OR of draw_objects[j] over all j not equal to i), gated by OBJ_COLLIDE_EN.
REQ-016 Per-object accumulators SHALL OR pixel hits over each frame.
REQ-017 On a cycle with startOfFrame high, the outputs SHALL load the accumulator contents, excluding the current pixel. In the same cycle, the accumulators SHALL load only that cycle's pixel hits.
REQ-018 Published results SHALL become visible one cycle after startOfFrame. They SHALL hold constant until one cycle after the next startOfFrame.
REQ-019 collision_pulse SHALL be high for exactly the cycle in which the outputs update, and only if any published collision bit is 1.
REQ-020 collision_count SHALL increment by 1 in the cycle collision_pulse is high, and SHALL saturate at 2^COUNT_W-1 with no wrap.
REQ-021 If startOfFrame is high in two consecutive cycles, the second publish SHALL contain only the hits from the first cycle.
REQ-022 Multiple objects touching the same border pixel SHALL each record the hit.
REQ-023 Multiple sides in one pixel (corner) SHALL set all corresponding border_hit bits.
REQ-024 Before the first startOfFrame after reset, all outputs SHALL stay 0, and accumulation SHALL proceed normally.

Reset
REQ-025 While reset is high, accumulators, border_hit, object_hit, collision, collision_pulse and collision_count SHALL all be 0 on the next edge.
REQ-026 When reset is asserted mid-frame, the partial frame SHALL be discarded, and the first publish after release SHALL reflect only post-reset hits.
REQ-027 Reset SHALL take priority over a coincident startOfFrame.

Structure
REQ-028 Shared package pinball_pkg SHALL hold the constants NUM_BORDERS=4 and BORDER_TOP=0, BORDER_BOTTOM=1, BORDER_LEFT=2, BORDER_RIGHT=3.
REQ-029 Sub-module collision_accumulator SHALL be instantiated once per object. Its per-object behaviour SHALL be:
- 5 hit inputs (4 sides plus object hit);
- startOfFrame input;
- accumulation per REQ-016;
- publish per REQ-017;
- registered 5-bit result.
REQ-030 The top level SHALL hold the pair-overlap logic, the collision OR, the pulse and the counter.

Verification (NUM_OBJECTS=4, COUNT_W=4)
REQ-031 Stimulus: object 1 and draw_borders=4'b0001 high for 1 cycle mid-frame, then startOfFrame. Required response: border_hit[7:4]=4'b0001, collision=4'b0010, and a 1-cycle collision_pulse.
REQ-032 Stimulus: objects 0 and 3 overlap 10 pixels. Required response, with OBJ_COLLIDE_EN=1: object_hit=4'b1001 next frame. Required response, with OBJ_COLLIDE_EN=0: object_hit=0 and no pulse.
REQ-033 Stimulus: a hit coincident with the startOfFrame cycle only. Required response: it is absent from that publish and present in the following publish.
REQ-034 Stimulus: 20 consecutive frames each with a collision. Required response: collision_count reaches 15 and holds at 15.
REQ-035 Stimulus: a hit mid-frame, then reset for 1 cycle, then a clean frame. Required response: the next publish gives all outputs 0 and no pulse.
REQ-036 Stimulus: corner pixel draw_borders=4'b0101 with object 2. Required response: border_hit[11:8]=4'b0101.
